// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Per-channel switch synchronizer and counter-based debouncer
//                with optional one-cycle rise/fall pulses.
//                Optional macro SW_DEBOUNCE_PULSE_EN enables the pulse flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int               C_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] w_update;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_ch
            logic [C_CNT_W-1:0] r_cnt;
            logic               w_differ;
            logic               w_expire;

            assign w_differ     = r_sync2[gi] ^ r_db[gi];
            // The disagreement has persisted for DEBOUNCE_CYCLES edges, including this one.
            assign w_expire     = w_differ && (r_cnt == C_CNT_MAX);
            assign w_update[gi] = w_expire;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!w_differ || w_expire) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db <= '0;
        end else begin
            r_db <= r_db ^ w_update;
        end
    end

    assign sw_db = r_db;

`ifdef SW_DEBOUNCE_PULSE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // Pulses are registered on the same edge that flips sw_db, so they coincide with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_update & r_sync2;
            r_fall <= w_update & ~r_sync2;
        end
    end

    assign sw_rise = r_rise;
    assign sw_fall = r_fall;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// Testbench for sw_debounce: scenario tasks compared against a behavioural
// model built on synchronizer delay and disagreement run length.
module tb_sw_debounce;

    localparam int DC = 4;
`ifdef SW_DEBOUNCE_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw = 2'b11;
    wire  [1:0] sw_db;
    wire  [1:0] sw_rise;
    wire  [1:0] sw_fall;
    wire        ha_sum;
    wire        ha_carry;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(DC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    // downstream half adder fed by the debounced levels
    assign ha_sum   = sw_db[0] ^ sw_db[1];
    assign ha_carry = sw_db[0] & sw_db[1];

    // reference model: sample history and disagreement run length per channel
    logic [1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    int         m_run [2];

    function automatic void model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_db = 2'b00; m_rise = 2'b00; m_fall = 2'b00;
        m_run[0] = 0; m_run[1] = 0;
    endfunction

    function automatic void model_edge(input logic [1:0] v);
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (m_s2[i] !== m_db[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DC) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                    if (PULSE) begin
                        if (m_db[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = v;
    endfunction

    function automatic logic [7:0] got_v();
        return {sw_db, sw_rise, sw_fall, ha_sum, ha_carry};
    endfunction

    function automatic logic [7:0] exp_v();
        return {m_db, m_rise, m_fall, m_db[0] ^ m_db[1], m_db[0] & m_db[1]};
    endfunction

    task automatic step(input logic [1:0] v);
        sw = v;
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    task automatic test_reset();
        sw = 2'b11;
        rst_n = 1'b0;
        model_reset();
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (got_v() !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_edge%0d: got %b expected %b", e, got_v(), 8'h00);
            end
            #3;
            n_cmp++;
            if (got_v() !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_mid%0d: got %b expected %b", e, got_v(), 8'h00);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_hold_through_reset();
        int first0 = -1, first1 = -1, nr0 = 0, nr1 = 0;
        for (int e = 1; e <= 10; e++) begin
            step(2'b11);
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL hold_rel e%0d: got %b expected %b", e, got_v(), exp_v());
            end
            if (sw_db[0] && first0 < 0) first0 = e;
            if (sw_db[1] && first1 < 0) first1 = e;
            nr0 += int'(sw_rise[0]);
            nr1 += int'(sw_rise[1]);
        end
        n_cmp++;
        if (first0 != DC + 2 || first1 != DC + 2) begin
            n_bad++;
            $display("FAIL hold_rel_latency: got %0d/%0d expected %0d", first0, first1, DC + 2);
        end
        n_cmp++;
        if (nr0 != int'(PULSE) || nr1 != int'(PULSE)) begin
            n_bad++;
            $display("FAIL hold_rel_pulses: got %0d/%0d expected %0d", nr0, nr1, int'(PULSE));
        end
    endtask

    task automatic test_release();
        int f0 = -1, f1 = -1;
        logic [1:0] fall_at = 2'b00;
        for (int e = 1; e <= 10; e++) begin
            step(2'b00);
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL release e%0d: got %b expected %b", e, got_v(), exp_v());
            end
            if (!sw_db[0] && f0 < 0) f0 = e;
            if (!sw_db[1] && f1 < 0) begin
                f1 = e;
                fall_at = sw_fall;
            end
        end
        n_cmp++;
        if (f0 != DC + 2 || f1 != DC + 2) begin
            n_bad++;
            $display("FAIL release_edge: got %0d/%0d expected %0d", f0, f1, DC + 2);
        end
        n_cmp++;
        if (fall_at !== (PULSE ? 2'b11 : 2'b00)) begin
            n_bad++;
            $display("FAIL release_fall: got %b expected %b", fall_at, PULSE ? 2'b11 : 2'b00);
        end
        n_cmp++;
        if ({ha_sum, ha_carry} !== 2'b00) begin
            n_bad++;
            $display("FAIL release_ha: got %b expected %b", {ha_sum, ha_carry}, 2'b00);
        end
    endtask

    task automatic test_clean_press();
        int first = -1, nr = 0;
        for (int e = 1; e <= 10; e++) begin
            step(2'b01);
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL press e%0d: got %b expected %b", e, got_v(), exp_v());
            end
            if (sw_db[0] && first < 0) first = e;
            nr += int'(sw_rise[0]);
        end
        n_cmp++;
        if (first != DC + 2 || nr != int'(PULSE)) begin
            n_bad++;
            $display("FAIL press_latency: got edge %0d pulses %0d expected edge %0d pulses %0d",
                     first, nr, DC + 2, int'(PULSE));
        end
    endtask

    task automatic test_bounce();
        logic [1:0] pat [4] = '{2'b11, 2'b01, 2'b11, 2'b01};
        int first = -1, nr = 0;
        for (int k = 0; k < 4; k++) begin
            step(pat[k]);
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL bounce k%0d: got %b expected %b", k, got_v(), exp_v());
            end
        end
        for (int e = 1; e <= 10; e++) begin
            step(2'b11);
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL bounce_hold e%0d: got %b expected %b", e, got_v(), exp_v());
            end
            if (sw_db[1] && first < 0) first = e;
            nr += int'(sw_rise[1]);
        end
        n_cmp++;
        if (first != DC + 2 || nr != int'(PULSE)) begin
            n_bad++;
            $display("FAIL bounce_latency: got edge %0d pulses %0d expected edge %0d pulses %0d",
                     first, nr, DC + 2, int'(PULSE));
        end
    endtask

    task automatic test_reset_mid_count();
        int first = -1, nr = 0;
        // asynchronous assertion with sw_db high and no clock edge in between
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (got_v() !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected %b", got_v(), 8'h00);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(2'b01);
        rst_n = 1'b0;
        #1;
        model_reset();
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(2'b01);
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL midcount e%0d: got %b expected %b", e, got_v(), exp_v());
            end
            if (sw_db[0] && first < 0) first = e;
            nr += int'(sw_rise[0]);
        end
        n_cmp++;
        if (first != DC + 2 || nr != int'(PULSE)) begin
            n_bad++;
            $display("FAIL midcount_latency: got edge %0d pulses %0d expected edge %0d pulses %0d",
                     first, nr, DC + 2, int'(PULSE));
        end
    endtask

    task automatic test_random();
        logic [1:0] cur = 2'b00;
        int         left = 0;
        for (int k = 0; k < 400; k++) begin
            if (left == 0) begin
                cur  = 2'($urandom_range(0, 3));
                left = $urandom_range(1, 8);
            end
            step(cur);
            left--;
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL random k%0d: got %b expected %b", k, got_v(), exp_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_through_reset();
        test_release();
        test_clean_press();
        test_bounce();
        test_reset_mid_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
